demux_1to2_16bit_buf: RTL

Buffered 1-to-2 demultiplexer: accepts 16-bit words from a single valid/ready source and steers each word to output channel A or B according to `sel`, with a small FIFO per channel. It is the distribution counterpart of the 2:1 16-bit data-path mux in the MU0 library. It feeds two independent consumers from one producer without the producer stalling on the channel it is not using.

---
 rtl/demux_1to2_16bit_buf.sv | 136 +++++++++++++
 1 files changed

// File: rtl/demux_1to2_16bit_buf.sv
// Buffered 1-to-2 demultiplexer: one valid/ready producer steers each word to
// channel A or B by `sel`, with an independent DEPTH-entry FIFO per channel.

// One channel FIFO. Storage is cleared on reset, so the head reads as zero
// when the channel is empty.
module demux_1to2_16bit_buf_chan #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop_req,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_q == FULL_CNT);
  assign valid = (count_q != '0);
  assign count = count_q;
  assign rdata = valid ? mem_q[rd_ptr_q] : '0;

  // A full channel refuses the push even when it pops on the same edge.
  assign wr_en = push && !full;
  assign rd_en = pop_req && valid;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

module demux_1to2_16bit_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         d,
  input  logic                     sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         qa,
  output logic                     qa_valid,
  input  logic                     qa_ready,
  output logic [WIDTH-1:0]         qb,
  output logic                     qb_valid,
  input  logic                     qb_ready,
  output logic [$clog2(DEPTH):0]   count_a,
  output logic [$clog2(DEPTH):0]   count_b
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; ready never depends on valid, and the producer holds its
  // payload stable until the transfer. in_ready looks only at the selected
  // channel's registered fill level, never at the consumer readies.
  logic full_a;
  logic full_b;
  logic push_a;
  logic push_b;

  assign in_ready = sel ? !full_b : !full_a;
  assign push_a   = in_valid && in_ready && !sel;
  assign push_b   = in_valid && in_ready && sel;

  demux_1to2_16bit_buf_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan_a (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_a),
    .wdata   (d),
    .pop_req (qa_ready),
    .rdata   (qa),
    .valid   (qa_valid),
    .full    (full_a),
    .count   (count_a)
  );

  demux_1to2_16bit_buf_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan_b (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_b),
    .wdata   (d),
    .pop_req (qb_ready),
    .rdata   (qb),
    .valid   (qb_valid),
    .full    (full_b),
    .count   (count_b)
  );

endmodule
